// File: rtl/pdm_decoder_if.sv
// Decoded-sample stream between the PDM decoder and its consumer: valid/ready
// handshake plus the sticky overrun flag and its clear.
interface pdm_decoder_if #(
    parameter int OUT_W = 10
);
    logic [OUT_W-1:0] sample;
    logic             sample_valid;
    logic             sample_ready;
    logic             overrun;
    logic             overrun_clr;

    modport master (
        output sample, sample_valid, overrun,
        input  sample_ready, overrun_clr
    );

    modport slave (
        input  sample, sample_valid, overrun,
        output sample_ready, overrun_clr
    );
endinterface

// File: rtl/pdm_decoder.sv
// PDM-to-PCM decimator: counts ones over 2^DECIM_LOG2-cycle windows; sample is valid 1 cycle after window end.
// A single holding register: an unconsumed sample is overwritten by the next one and overrun is flagged.
module pdm_decoder #(
    parameter int DECIM_LOG2 = 10,
    parameter int OUT_W      = 10,
    parameter int SETTLE     = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          pdm_in,
    output logic [1:0]    state,
    pdm_decoder_if.master sif
);

    localparam int CW = DECIM_LOG2 + 1;
    localparam int unsigned RSH = (DECIM_LOG2 >= OUT_W) ? (DECIM_LOG2 - OUT_W) : 0;
    localparam int unsigned LSH = (OUT_W > DECIM_LOG2) ? (OUT_W - DECIM_LOG2) : 0;
    localparam logic [32:0] SAT_MAX     = (33'd1 << OUT_W) - 33'd1;
    localparam logic [3:0]  SETTLE_LAST = 4'((SETTLE > 0) ? (SETTLE - 1) : 0);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SETTLE = 2'b01,
        ST_RUN    = 2'b10
    } state_t;

    state_t                 state_q, state_d;
    logic                   sync1_q, sync2_q;
    logic [DECIM_LOG2-1:0]  cnt_q, cnt_d;
    logic [CW-1:0]          acc_q, acc_d;
    logic [3:0]             settle_q, settle_d;
    logic [OUT_W-1:0]       sample_q, sample_d;
    logic                   valid_q, valid_d;
    logic                   ovr_q, ovr_d;

    logic                   win_end;
    logic                   active;
    logic                   load;
    logic [CW-1:0]          count;
    logic [32:0]            wide;
    logic [OUT_W-1:0]       scaled;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            settle_q <= '0;
            sample_q <= '0;
            valid_q  <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sync1_q  <= pdm_in;
            sync2_q  <= sync1_q;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            settle_q <= settle_d;
            sample_q <= sample_d;
            valid_q  <= valid_d;
            ovr_q    <= ovr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        win_end  = &cnt_q;
        case (state_q)
            ST_IDLE: begin
                settle_d = '0;
                if (en) state_d = (SETTLE == 0) ? ST_RUN : ST_SETTLE;
            end
            ST_SETTLE: begin
                if (!en) begin
                    state_d = ST_IDLE;
                end else if (win_end) begin
                    if (settle_q == SETTLE_LAST) state_d = ST_RUN;
                    else                         settle_d = settle_q + 4'd1;
                end
            end
            ST_RUN: begin
                settle_d = '0;
                if (!en) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Window end already includes the current cycle's bit, so a full window counts 0..2^DECIM_LOG2.
    always_comb begin
        active = (state_q != ST_IDLE) && en;
        count  = acc_q + CW'(sync2_q);
        cnt_d  = active ? (cnt_q + DECIM_LOG2'(1)) : '0;
        acc_d  = (active && !win_end) ? count : '0;
        wide   = (33'(count) >> RSH) << LSH;
        scaled = (wide > SAT_MAX) ? SAT_MAX[OUT_W-1:0] : wide[OUT_W-1:0];
    end

    always_comb begin
        load     = (state_q == ST_RUN) && win_end;
        valid_d  = load | (valid_q & ~sif.sample_ready);
        sample_d = load ? scaled : sample_q;
        ovr_d    = (load & valid_q & ~sif.sample_ready) | (ovr_q & ~sif.overrun_clr);
    end

    assign state            = state_q;
    assign sif.sample       = sample_q;
    assign sif.sample_valid = valid_q;
    assign sif.overrun      = ovr_q;

endmodule

// File: tb/tb_pdm_decoder.sv
// Directed bench for pdm_decoder at default parameters: window timing, density table,
// overrun handling, en drop / re-enable, and asynchronous reset.
module tb_pdm_decoder;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic       en     = 1'b0;
    logic       pdm_in = 1'b0;
    logic [1:0] state;

    pdm_decoder_if #(.OUT_W(10)) sif ();

    pdm_decoder #(.DECIM_LOG2(10), .OUT_W(10), .SETTLE(1)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .pdm_in (pdm_in),
        .state  (state),
        .sif    (sif)
    );

    always #5 clk = ~clk;

    int         errors = 0;
    int         checks = 0;
    logic [7:0] pat    = 8'h00;
    int         phase  = 0;

    // Pin stream: 8-cycle repeating pattern, updated 2 ns after each edge.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            pdm_in = pat[phase[2:0]];
            phase++;
        end
    end

    typedef struct {
        string      name;
        logic [7:0] pat;
        int         exp;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (sif.sample_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL wait_valid: got no sample_valid expected one within 3000 cycles");
        end
    endtask

    // Raises en just after an edge (cycle 0) and checks the state/first-sample timeline.
    task automatic run_from_enable(input string tag, input int exp_sample);
        int first;
        first = 0;
        @(posedge clk);
        #1 en = 1'b1;
        for (int c = 1; c <= 2049; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (c == 1)    check({tag, "_state_c1"}, int'(state), 1);
            if (c == 1024) check({tag, "_state_c1024"}, int'(state), 1);
            if (c == 1025) check({tag, "_state_c1025"}, int'(state), 2);
            if (first == 0 && sif.sample_valid === 1'b1) first = c;
        end
        check({tag, "_first_valid_cycle"}, first, 2049);
        check({tag, "_first_sample"}, int'(sif.sample), exp_sample);
    endtask

    initial begin
        bit ok;
        int seen;

        vecs[0] = '{"dens_zero",  8'h00, 0};
        vecs[1] = '{"dens_ones",  8'hFF, 1023};
        vecs[2] = '{"dens_half",  8'h55, 512};
        vecs[3] = '{"dens_qtr",   8'h11, 256};
        vecs[4] = '{"dens_3qtr",  8'h77, 768};
        vecs[5] = '{"dens_8th",   8'h01, 128};

        sif.sample_ready = 1'b1;
        sif.overrun_clr  = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_sample", int'(sif.sample), 0);
        check("rst_valid", int'(sif.sample_valid), 0);
        check("rst_overrun", int'(sif.overrun), 0);
        check("rst_state", int'(state), 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_state", int'(state), 0);

        // Enable timeline with silent input
        pat = 8'h00;
        run_from_enable("en0", 0);

        // Density table, consumer always ready
        for (int v = 0; v < 6; v++) begin
            pat = vecs[v].pat;
            wait_valid(ok);
            @(posedge clk);
            for (int k = 0; k < 2; k++) begin
                wait_valid(ok);
                if (ok) check(vecs[v].name, int'(sif.sample), vecs[v].exp);
                @(posedge clk);
            end
            if (v == 1) check("ones_overrun", int'(sif.overrun), 0);
        end

        // Overrun: consumer stalls across two window ends
        pat = 8'h00;
        wait_valid(ok);
        @(posedge clk);
        wait_valid(ok);
        @(posedge clk);
        #1;
        sif.sample_ready = 1'b0;
        pat = 8'hFF;
        repeat (1030) @(posedge clk);
        @(negedge clk);
        check("ovr_first_valid", int'(sif.sample_valid), 1);
        check("ovr_first_flag", int'(sif.overrun), 0);
        check("ovr_first_sample", int'(sif.sample), 1021);
        repeat (1024) @(posedge clk);
        @(negedge clk);
        check("ovr_second_valid", int'(sif.sample_valid), 1);
        check("ovr_second_flag", int'(sif.overrun), 1);
        check("ovr_second_sample", int'(sif.sample), 1023);
        sif.overrun_clr = 1'b1;
        @(negedge clk);
        sif.overrun_clr = 1'b0;
        check("ovr_cleared", int'(sif.overrun), 0);
        check("ovr_hold_sample", int'(sif.sample), 1023);
        sif.sample_ready = 1'b1;
        @(negedge clk);
        check("ovr_drained", int'(sif.sample_valid), 0);

        // en dropped mid-window in RUN
        @(posedge clk);
        #1 en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("endrop_state", int'(state), 0);
        seen = 0;
        for (int i = 0; i < 1100; i++) begin
            @(negedge clk);
            if (sif.sample_valid === 1'b1) seen++;
        end
        check("endrop_no_sample", seen, 0);
        pat = 8'h55;
        run_from_enable("reen", 512);

        // Asynchronous reset with a pending sample and overrun set
        sif.sample_ready = 1'b0;
        wait_valid(ok);
        repeat (1024) @(negedge clk);
        check("pre_rst_valid", int'(sif.sample_valid), 1);
        check("pre_rst_overrun", int'(sif.overrun), 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_sample", int'(sif.sample), 0);
        check("arst_valid", int'(sif.sample_valid), 0);
        check("arst_overrun", int'(sif.overrun), 0);
        check("arst_state", int'(state), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("post_rst_state", int'(state), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
